// File: rtl/adc_drv.sv
`default_nettype none
// ============================================================================
//  Module   : adc_drv
//  Purpose  : I2S capture driver for a 24-bit stereo ADC. Generates the ADC
//             bit clock and word clock from the system clock, deserialises
//             sdata_i into per-channel samples and offers each completed
//             sample to the mixer through a per-channel push/ack handshake
//             (bit 0 = left, bit 1 = right).
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk      in   1         system clock, 24.576 MHz
//    rst      in   1         asynchronous, active-low reset
//    sdata_i  in   1         serial data from ADC, MSB first
//    bck_o    out  1         bit clock to ADC
//    lrck_o   out  1         word clock to ADC; 0 = left half, 1 = right half
//    data_o   out  SAMPLE_W  sample for the channel currently offered
//    push_o   out  2         per-channel sample pending (level)
//    ack_i    in   2         per-channel consume strobe (1 clk)
//    ovf_o    out  2         per-channel sticky overrun flag
// ----------------------------------------------------------------------------
//  Build option
//    ADC_DRV_LJ_EN  defined   : left-justified, MSB in slot 0 of each half
//                   undefined : standard I2S, MSB in slot 1 (1-BCK delay)
// ============================================================================
module adc_drv #(
    parameter int BCK_DIV_LOG2 = 3,   // log2(clk cycles per BCK)
    parameter int SAMPLE_W     = 24   // sample width, 2..31
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sdata_i,
    output logic                bck_o,
    output logic                lrck_o,
    output logic [SAMPLE_W-1:0] data_o,
    output logic [1:0]          push_o,
    input  logic [1:0]          ack_i,
    output logic [1:0]          ovf_o
);

    // Divider values: wrap point, BCK rising edge (sample) and the cycle after
    localparam logic [BCK_DIV_LOG2-1:0] c_CNT_MAX    = {BCK_DIV_LOG2{1'b1}};
    localparam logic [BCK_DIV_LOG2-1:0] c_CNT_SAMPLE =
        BCK_DIV_LOG2'((1 << (BCK_DIV_LOG2 - 1)) - 1);
    localparam logic [BCK_DIV_LOG2-1:0] c_CNT_DONE   =
        BCK_DIV_LOG2'(1 << (BCK_DIV_LOG2 - 1));

    // Slot (within a 32-slot half frame) that carries the sample LSB
`ifdef ADC_DRV_LJ_EN
    localparam logic [4:0] c_LSB_SLOT = 5'(SAMPLE_W - 1);
`else
    localparam logic [4:0] c_LSB_SLOT = 5'(SAMPLE_W);
`endif

    logic [BCK_DIV_LOG2-1:0] cnt_q,    cnt_d;
    logic [5:0]              bitcnt_q, bitcnt_d;
    logic                    lrck_q,   lrck_d;
    logic [SAMPLE_W-1:0]     shift_q,  shift_d;
    logic [SAMPLE_W-1:0]     hold_l_q, hold_l_d;
    logic [SAMPLE_W-1:0]     hold_r_q, hold_r_d;
    logic [1:0]              valid_q,  valid_d;
    logic [1:0]              ovf_q,    ovf_d;

    logic                    w_sample_en;
    logic                    w_cap_done;
    logic [1:0]              w_cap;

    // ------------------------------------------------------------------------
    // Clock generation and deserialiser
    // ------------------------------------------------------------------------
    always_comb begin
        cnt_d    = cnt_q + BCK_DIV_LOG2'(1);
        bitcnt_d = bitcnt_q;
        if (cnt_q == c_CNT_MAX) begin
            bitcnt_d = bitcnt_q + 6'd1;
        end
        // Tracks bitcnt_d so lrck_o changes on the same edge as the BCK fall
        lrck_d = bitcnt_d[5];
    end

    // The shifter runs on every BCK rising edge. Slots outside the sample
    // window simply fall off the top, so once the LSB slot has been sampled
    // the register holds exactly the MSB..LSB window.
    assign w_sample_en = (cnt_q == c_CNT_SAMPLE);

    always_comb begin
        shift_d = shift_q;
        if (w_sample_en) begin
            shift_d = {shift_q[SAMPLE_W-2:0], sdata_i};
        end
    end

    // Capture completes one clk after the LSB was sampled; bitcnt has not
    // moved yet at that point, so bitcnt[5] still names the channel.
    assign w_cap_done = (cnt_q == c_CNT_DONE) && (bitcnt_q[4:0] == c_LSB_SLOT);
    assign w_cap      = {w_cap_done & bitcnt_q[5], w_cap_done & ~bitcnt_q[5]};

    // ------------------------------------------------------------------------
    // Holding registers and handshake
    // ------------------------------------------------------------------------
    always_comb begin
        hold_l_d = w_cap[0] ? shift_q : hold_l_q;
        hold_r_d = w_cap[1] ? shift_q : hold_r_q;
    end

    // A capture beats a simultaneous ack: the new sample stays pending and,
    // since the old one was consumed in that same cycle, no overrun is flagged.
    always_comb begin
        valid_d = valid_q;
        ovf_d   = ovf_q;
        for (int ch = 0; ch < 2; ch++) begin
            if (w_cap[ch]) begin
                valid_d[ch] = 1'b1;
                if (valid_q[ch] && !ack_i[ch]) begin
                    ovf_d[ch] = 1'b1;
                end
            end else if (ack_i[ch]) begin
                valid_d[ch] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            bitcnt_q <= '0;
            lrck_q   <= 1'b0;
            shift_q  <= '0;
            hold_l_q <= '0;
            hold_r_q <= '0;
            valid_q  <= '0;
            ovf_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
            lrck_q   <= lrck_d;
            shift_q  <= shift_d;
            hold_l_q <= hold_l_d;
            hold_r_q <= hold_r_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bck_o  = cnt_q[BCK_DIV_LOG2-1];
    assign lrck_o = lrck_q;
    // Left has priority; a completed right sample waits in hold_r
    assign data_o = valid_q[0] ? hold_l_q : hold_r_q;
    assign push_o = valid_q;
    assign ovf_o  = ovf_q;

endmodule
`default_nettype wire
